// File: rtl/usb_tx_packet_encoder.sv
// usb_tx_packet_encoder: USB full-speed tx encoder (SYNC, PID, payload, CRC16, EOP; NRZI + bit stuffing).
// Ports: clk/n_rst, tx_packet/buffer_occupancy in, tx_packet_data+get_tx_packet_data pop, dplus/dminus/active/error out. Option: USB_TX_STALL_EN.
module usb_tx_packet_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] C_DATA0 = 3'd1;
  localparam logic [2:0] C_ACK   = 3'd2;
  localparam logic [2:0] C_NAK   = 3'd3;
  localparam logic [2:0] C_STALL = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    code_q, code_d;
  logic [6:0]    rem_q, rem_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    ones_q, ones_d;
  logic          stuff_q, stuff_d;
  logic [15:0]   crc_q, crc_d;
  logic          lj_q, lj_d;
  logic          se0_q, se0_d;
  logic          err_q, err_d;

  logic       legal;
  logic [7:0] pid_byte;
  logic [6:0] occ_cap;
  logic       bit_end;
  logic [2:0] ones_n;
  logic       pop;
  logic       emit;
  logic       emit_stuff;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    crc_step = (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  always_comb begin
    legal = (tx_packet == C_DATA0) ||
            (tx_packet == C_ACK) ||
            (tx_packet == C_NAK);
`ifdef USB_TX_STALL_EN
    legal = legal || (tx_packet == C_STALL);
`endif
  end

  always_comb begin
    case (code_q)
      C_DATA0: pid_byte = 8'hC3;
      C_ACK:   pid_byte = 8'hD2;
      C_NAK:   pid_byte = 8'h5A;
      default: pid_byte = 8'h1E;
    endcase
  end

  assign occ_cap = (buffer_occupancy > 7'd64) ? 7'd64 : buffer_occupancy;
  assign bit_end = (tmr_q == T_LAST);
  assign ones_n  = sh_q[0] ? ones_q + 3'd1 : 3'd0;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    rem_d      = rem_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    ones_d     = ones_q;
    stuff_d    = stuff_q;
    crc_d      = crc_q;
    lj_d       = lj_q;
    se0_d      = se0_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    emit       = 1'b0;
    emit_stuff = 1'b0;
    tmr_d      = tmr_q + TW'(1);
    if (state_q == S_IDLE || bit_end)
      tmr_d = '0;

    if (state_q == S_IDLE) begin
      if (tx_packet != 3'd0) begin
        if (legal) begin
          state_d = S_SYNC;
          code_d  = tx_packet;
          rem_d   = occ_cap;
          sh_d    = SYNC_BYTE;
          idx_d   = 3'd0;
          ones_d  = 3'd0;
          stuff_d = 1'b0;
          crc_d   = 16'hFFFF;
          emit    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bit_end) begin
      emit = 1'b1;
      if (stuff_q) begin
        // stuffed bit done; the pointer was already advanced
        stuff_d = 1'b0;
      end else begin
        unique case (state_q)
          S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI: begin
            if (state_q == S_DATA)
              crc_d = crc_step(crc_q, sh_q[0]);
            if (idx_q != 3'd7) begin
              sh_d  = sh_q >> 1;
              idx_d = idx_q + 3'd1;
            end else begin
              idx_d = 3'd0;
              unique case (state_q)
                S_SYNC: begin
                  state_d = S_PID;
                  sh_d    = pid_byte;
                end
                S_PID, S_DATA: begin
                  if (code_q != C_DATA0) begin
                    state_d = S_EOP_SE0;
                  end else if (rem_q != 7'd0) begin
                    pop     = 1'b1;
                    sh_d    = tx_packet_data;
                    rem_d   = rem_q - 7'd1;
                    state_d = S_DATA;
                  end else begin
                    state_d = S_CRC_LO;
                    sh_d    = ~crc_d[7:0];
                  end
                end
                S_CRC_LO: begin
                  state_d = S_CRC_HI;
                  sh_d    = ~crc_q[15:8];
                end
                S_CRC_HI: state_d = S_EOP_SE0;
                default: ;
              endcase
            end
            if (ones_n == 3'd6) begin
              stuff_d    = 1'b1;
              ones_d     = 3'd0;
              emit_stuff = 1'b1;
            end else begin
              ones_d = ones_n;
            end
          end
          S_EOP_SE0: begin
            if (idx_q == 3'd1) begin
              state_d = S_EOP_J;
              idx_d   = 3'd0;
            end else begin
              idx_d = 3'd1;
            end
          end
          S_EOP_J: state_d = S_IDLE;
          default: ;
        endcase
      end
    end

    // drive the symbol for the bit period that starts next
    if (emit) begin
      if (emit_stuff) begin
        lj_d  = ~lj_q;
        se0_d = 1'b0;
      end else begin
        unique case (state_d)
          S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI: begin
            lj_d  = sh_d[0] ? lj_q : ~lj_q;
            se0_d = 1'b0;
          end
          S_EOP_SE0: se0_d = 1'b1;
          S_EOP_J, S_IDLE: begin
            se0_d = 1'b0;
            lj_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
      rem_q   <= 7'd0;
      sh_q    <= 8'd0;
      idx_q   <= 3'd0;
      tmr_q   <= '0;
      ones_q  <= 3'd0;
      stuff_q <= 1'b0;
      crc_q   <= 16'hFFFF;
      lj_q    <= 1'b1;
      se0_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      crc_q   <= crc_d;
      lj_q    <= lj_d;
      se0_q   <= se0_d;
      err_q   <= err_d;
    end
  end

  assign get_tx_packet_data = pop;
  assign dplus_out          = ~se0_q & lj_q;
  assign dminus_out         = ~se0_q & ~lj_q;
  assign tx_transfer_active = (state_q != S_IDLE);
  assign tx_error           = err_q;

endmodule
